dec_onehot_n_pipe: RTL
======================

Name: dec_onehot_n_pipe

Overview:
- Parametrised, registered successor to the combinational 4-input / 10-output active-low code decoder.
- Accepts an SEL_W-bit code (bit 0 = LSB) over a valid/ready handshake.
- Decodes the code to an active-low one-hot word of NUM_OUT bits, flags out-of-range codes, and keeps a saturating error count.
- A 2-entry output buffer sits between the decoder and downstream logic so backpressure never drops a code.

Parameters:
- SEL_W, 4: code width; legal 1..8.
- NUM_OUT, 10: number of decoded outputs; legal 2..2**SEL_W.
- OOR_HOLD, 0: out-of-range policy. 0 = emit all-ones. 1 = repeat last in-range pattern.
- ERR_CNT_W, 8: width of the error counter.

Ports:
- clk, in, 1: single clock; all state changes on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- in_valid, in, 1: in_code is valid.
- in_ready, out, 1: block can accept a code.
- in_code, in, SEL_W: code to decode.
- out_valid, out, 1: out_n and out_oor are valid.
- out_ready, in, 1: downstream accepts.
- out_n, out, NUM_OUT: active-low one-hot; bit k is low when the decoded code equals k.
- out_oor, out, 1: the entry at the head came from a code >= NUM_OUT.
- err_cnt, out, ERR_CNT_W: saturating count of accepted out-of-range codes.
- err_clr, in, 1: synchronous clear of err_cnt.

Behaviour:
- Reset (async assert, released on a clock edge):
  - buffer EMPTY, so out_valid=0 and in_ready=1.
  - out_n all ones, out_oor=0, err_cnt=0.
  - Hold-mode last-pattern register set to all ones.
- Accept and pop conditions:
  - Accept (push) = in_valid & in_ready.
  - Pop = out_valid & out_ready.
- Latency: a code accepted at edge t appears on out_n/out_valid immediately after edge t (1 cycle).
- Decode, done at push time and stored per entry:
  - code < NUM_OUT: the stored pattern has only bit[code]=0; oor=0.
  - code >= NUM_OUT, OOR_HOLD=0: pattern all ones, oor=1.
  - code >= NUM_OUT, OOR_HOLD=1: pattern = last in-range pattern (all ones if none since reset), oor=1.
  - The last-pattern register updates only on in-range pushes.
- Buffer FSM, states EMPTY / ONE / TWO:
  - EMPTY: push -> ONE.
  - ONE: push & !pop -> TWO; pop & !push -> EMPTY; push & pop -> ONE, with the new entry at the head.
  - TWO: pop -> ONE. No push is possible because in_ready=0.
  - in_ready = (state != TWO), decoded directly from the registered state with no combinational path from out_ready.
  - out_valid = (state != EMPTY).
- Output stability:
  - While out_valid=1 and out_ready=0, out_n and out_oor stay constant.
  - While out_valid=0, out_n is forced to all ones and out_oor to 0.
- Error counter:
  - Increments by 1 on each out-of-range push; saturates at 2**ERR_CNT_W-1 with no wrap.
  - err_clr alone -> 0.
  - err_clr together with an out-of-range push -> 1, so the event is not lost.
  - The counter is independent of downstream backpressure.
- Reset mid-operation: buffered entries are discarded and all outputs return to reset values asynchronously. No output is produced for codes accepted before reset.
- Illegal parameters (NUM_OUT > 2**SEL_W) stop elaboration with an error.

Decomposition:
- Shared package dec_pkg holds:
  - the buffer state enum (EMPTY, ONE, TWO);
  - a function onehot_n(code, NUM_OUT) returning the active-low pattern;
  - the localparam for the all-ones word.
- One sub-module, dec_skid_buf2: the generic 2-entry valid/ready buffer, with data width = NUM_OUT+1.
- The top level holds the decode, the hold register and the error counter.

Test Plan:
- Reset, then hold out_ready=1 and stream codes 0..9 back-to-back. Required: out_n = 10'h3FE, 3FD, 3FB, ... 1FF on consecutive cycles, each 1 cycle after accept; out_oor=0; in_ready stays 1.
- OOR_HOLD=0, send codes 3, 12, 15. Required: out_n = 3F7, 3FF, 3FF; out_oor = 0,1,1; err_cnt = 2.
- OOR_HOLD=1, send codes 5, 13. Required: the second output is 3DF with out_oor=1.
- Backpressure: out_ready=0, present codes 1, 2, 3. Required:
  - only 1 and 2 are accepted; in_ready=0 after the second push;
  - out_n holds 3FD.
  - Then out_ready=1: 3FD, 3FB, 3F7 appear in order with no loss or duplicate.
- ERR_CNT_W=2, send 5 out-of-range codes. Required: err_cnt = 1, 2, 3, 3, 3. Then err_clr together with another out-of-range push gives err_cnt=1.
- Two entries buffered, assert rst mid-cycle. Required: out_valid=0, out_n all ones and in_ready=1 immediately, before the next edge. The first code after release decodes normally. Repeat with SEL_W=3, NUM_OUT=8.

Source files
------------

// File: rtl/dec_pkg.sv
// dec_pkg: shared types and helpers for the
// registered active-low one-hot decoder.
package dec_pkg;

    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT   = 1 << MAX_SEL_W;

    localparam logic [MAX_OUT-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    // Active-low one-hot of code; all ones when code is out of range.
    function automatic logic [MAX_OUT-1:0] onehot_n(
        input logic [MAX_SEL_W-1:0] code,
        input int                   num_out
    );
        logic [MAX_OUT-1:0] pat;
        pat = ALL_ONES;
        if (int'(code) < num_out) begin
            pat[code] = 1'b0;
        end
        return pat;
    endfunction

endpackage

// File: rtl/dec_skid_buf2.sv
// dec_skid_buf2: two-entry valid/ready buffer.
// in_ready comes only from registered state.
module dec_skid_buf2
    import dec_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_t   state;
    buf_state_t   state_nxt;
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         push;
    logic         pop;
    logic         head_from_in;
    logic         head_from_tail;
    logic         tail_from_in;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; push is impossible in TWO.
    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            (state == EMPTY): begin
                if (push) begin
                    state_nxt = ONE;
                end
            end
            (state == ONE): begin
                if (push && !pop) begin
                    state_nxt = TWO;
                end else if (pop && !push) begin
                    state_nxt = EMPTY;
                end
            end
            (state == TWO): begin
                if (pop) begin
                    state_nxt = ONE;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready  = (state != TWO);
        out_valid = (state != EMPTY);
        out_data  = head;
    end

    // Head is what downstream sees; tail holds the second entry.
    always_comb begin
        head_from_in   = push & ((state == EMPTY) | pop);
        tail_from_in   = push & ~pop & (state == ONE);
        head_from_tail = pop & (state == TWO);
    end

    // Entry storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (head_from_in) begin
                head <= in_data;
            end else if (head_from_tail) begin
                head <= tail;
            end
            if (tail_from_in) begin
                tail <= in_data;
            end
        end
    end

endmodule

// File: rtl/dec_onehot_n_pipe.sv
// dec_onehot_n_pipe: registered code decoder with
// out-of-range flag, hold mode and error counter.
module dec_onehot_n_pipe #(
    parameter int SEL_W     = 4,
    parameter int NUM_OUT   = 10,
    parameter int OOR_HOLD  = 0,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     in_code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_OUT-1:0]   out_n,
    output logic                 out_oor,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr
);

    import dec_pkg::*;

    if (SEL_W < 1 || SEL_W > MAX_SEL_W) begin : g_bad_sel_w
        $error("dec_onehot_n_pipe: SEL_W must be 1..8");
    end
    if (NUM_OUT < 2 || NUM_OUT > (1 << SEL_W)) begin : g_bad_num_out
        $error("dec_onehot_n_pipe: NUM_OUT must be 2..2**SEL_W");
    end
    if (ERR_CNT_W < 1) begin : g_bad_err_w
        $error("dec_onehot_n_pipe: ERR_CNT_W must be >= 1");
    end

    localparam int                 DW    = NUM_OUT + 1;
    localparam logic [SEL_W:0]     LIMIT = (SEL_W + 1)'(NUM_OUT);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);

    logic               push;
    logic               in_range;
    logic               push_oor;
    logic [NUM_OUT-1:0] dec_pat;
    logic [NUM_OUT-1:0] push_pat;
    logic [NUM_OUT-1:0] last_pat;
    logic [DW-1:0]      buf_data;
    logic               buf_valid;

    assign push     = in_valid & in_ready;
    assign in_range = ({1'b0, in_code} < LIMIT);

    // Decode at push time; out-of-range picks all ones or the held pattern.
    always_comb begin
        dec_pat  = NUM_OUT'(onehot_n(MAX_SEL_W'(in_code), NUM_OUT));
        push_oor = ~in_range;
        if (in_range) begin
            push_pat = dec_pat;
        end else if (OOR_HOLD != 0) begin
            push_pat = last_pat;
        end else begin
            push_pat = '1;
        end
    end

    // Last in-range pattern, used by hold mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_pat <= '1;
        end else if (push && in_range) begin
            last_pat <= dec_pat;
        end
    end

    // Saturating error count; a clear never swallows a same-cycle error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (push && push_oor) begin
            if (err_clr) begin
                err_cnt <= ERR_ONE;
            end else if (err_cnt != '1) begin
                err_cnt <= err_cnt + ERR_ONE;
            end
        end else if (err_clr) begin
            err_cnt <= '0;
        end
    end

    dec_skid_buf2 #(
        .W (DW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({push_oor, push_pat}),
        .out_valid (buf_valid),
        .out_ready (out_ready),
        .out_data  (buf_data)
    );

    // Idle outputs are forced so stale entries never leak downstream.
    always_comb begin
        out_valid = buf_valid;
        out_n     = buf_valid ? buf_data[NUM_OUT-1:0] : '1;
        out_oor   = buf_valid & buf_data[NUM_OUT];
    end

endmodule
